// File: rtl/l1i_pkg.sv
// Shared types, widths and helpers for the L1I refill controller.
package l1i_pkg;

    localparam int FetchingAddressWidth    = 64;
    localparam int CacheLineWith           = 512;
    localparam int OffsetWidth             = 6;
    localparam int BeatWidth               = 256;
    localparam int BeatsPerRefill          = 2 * CacheLineWith / BeatWidth;
    localparam int BeatCountWidth          = $clog2(BeatsPerRefill);
    localparam int PidSize                 = 20;
    localparam int TidSize                 = 16;
    localparam int InstructionCounterWidth = 64;
    localparam int QueueDepth              = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        UPDATE = 2'd3
    } refill_state_e;

    typedef struct packed {
        logic [FetchingAddressWidth-1:0]    address;
        logic [InstructionCounterWidth-1:0] inst_major_id;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
    } miss_entry_t;

    localparam int MissEntryWidth = $bits(miss_entry_t);

    // Bits that make two misses "the same refill": line address and owner Pid.
    localparam logic [MissEntryWidth-1:0] DupCompareMask = {
        {(FetchingAddressWidth - OffsetWidth){1'b1}}, {OffsetWidth{1'b0}},
        {InstructionCounterWidth{1'b0}},
        {PidSize{1'b1}},
        {TidSize{1'b0}}
    };

    // Clears the byte-offset bits, leaving the cacheline address.
    function automatic logic [FetchingAddressWidth-1:0] lineAddress(
        input logic [FetchingAddressWidth-1:0] addr
    );
        logic [FetchingAddressWidth-1:0] r;
        r = addr;
        r[OffsetWidth-1:0] = '0;
        return r;
    endfunction

endpackage

// File: rtl/miss_fifo.sv
// Synchronous FIFO for pending misses with a masked per-entry lookup so the
// owner can spot duplicates among queued (and in-flight head) entries.
// DEPTH must be a power of two: pointers wrap by natural overflow.
module miss_fifo #(
    parameter int            W          = 8,
    parameter int            DEPTH      = 2,
    parameter logic [W-1:0]  MATCH_MASK = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [W-1:0]     push_data_i,
    input  logic             pop_i,
    input  logic [W-1:0]     lookup_data_i,
    output logic [W-1:0]     head_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [DEPTH-1:0] lookup_hit_o
);

    localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]    mem_q [DEPTH];
    logic [W-1:0]    mem_d [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic [PtrW-1:0] age;
    logic            do_push, do_pop;

    assign full_o      = (count_q == (PtrW+1)'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign head_data_o = mem_q[rd_ptr_q];

    // Next pointers/storage; a push into a full FIFO is taken when a pop frees a slot.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end

    // Entry i is live when its distance from the read pointer is below the count.
    always_comb begin
        lookup_hit_o = '0;
        age          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = PtrW'(i) - rd_ptr_q;
            lookup_hit_o[i] = ({1'b0, age} < count_q) &&
                              (((mem_q[i] ^ lookup_data_i) & MATCH_MASK) == '0);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/l1i_refill_controller.sv
// L1I refill sequencer: queues misses, issues one line-pair read at a time,
// assembles four response beats into two lines and strobes the cache update.
// Handshakes: memReq_o is a valid held with a stable address until a rising
// edge sees memReqReady_i=1; each edge with memRespValid_i=1 in WAIT delivers
// one beat (no backpressure); cacheUpdate_o is a one-cycle strobe.
module l1i_refill_controller
    import l1i_pkg::*;
(
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               cacheMiss_i,
    input  logic [FetchingAddressWidth-1:0]    missedAddress_i,
    input  logic [InstructionCounterWidth-1:0] missedInstMajorId_i,
    input  logic [PidSize-1:0]                 missedPid_i,
    input  logic [TidSize-1:0]                 missedTid_i,
    output logic                               missOverflow_o,
    output logic                               memReq_o,
    output logic [FetchingAddressWidth-1:0]    memReqAddress_o,
    input  logic                               memReqReady_i,
    input  logic                               memRespValid_i,
    input  logic [BeatWidth-1:0]               memRespData_i,
    output logic                               cacheUpdate_o,
    output logic [FetchingAddressWidth-1:0]    cacheUpdateAddress_o,
    output logic [CacheLineWith-1:0]           cacheUpdateLine1_o,
    output logic [CacheLineWith-1:0]           cacheUpdateLine2_o,
    output logic [PidSize-1:0]                 cacheUpdatePid_o,
    output logic [TidSize-1:0]                 cacheUpdateTid_o,
    output logic [InstructionCounterWidth-1:0] cacheUpdateInstMajorId_o,
    output logic                               busy_o,
    output logic [1:0]                         fsmState_o
);

    localparam logic [BeatCountWidth-1:0] LastBeat = BeatCountWidth'(BeatsPerRefill - 1);

    refill_state_e                          state_q, state_d;
    logic [BeatCountWidth-1:0]              beat_cnt_q, beat_cnt_d;
    // Earlier beats shift in from the LSB end; the final beat completes the pair.
    logic [(BeatsPerRefill-1)*BeatWidth-1:0] beats_q, beats_d;
    logic                                   mem_req_q, mem_req_d;
    logic [FetchingAddressWidth-1:0]        mem_req_addr_q, mem_req_addr_d;
    logic                                   overflow_q, overflow_d;
    logic                                   update_q, update_d;
    logic [FetchingAddressWidth-1:0]        upd_addr_q, upd_addr_d;
    logic [CacheLineWith-1:0]               line1_q, line1_d, line2_q, line2_d;
    logic [PidSize-1:0]                     upd_pid_q, upd_pid_d;
    logic [TidSize-1:0]                     upd_tid_q, upd_tid_d;
    logic [InstructionCounterWidth-1:0]     upd_id_q, upd_id_d;

    miss_entry_t                 miss_entry, head_entry;
    logic [MissEntryWidth-1:0]   head_raw;
    logic                        fifo_full, fifo_empty, push, pop, is_dup;
    logic [QueueDepth-1:0]       lookup_hit;

    assign miss_entry = '{address: missedAddress_i, inst_major_id: missedInstMajorId_i,
                          pid: missedPid_i, tid: missedTid_i};
    assign head_entry = miss_entry_t'(head_raw);

    miss_fifo #(
        .W          (MissEntryWidth),
        .DEPTH      (QueueDepth),
        .MATCH_MASK (DupCompareMask)
    ) u_miss_fifo (
        .clk_i         (clock_i),
        .rst_ni        (reset_i),
        .push_i        (push),
        .push_data_i   (miss_entry),
        .pop_i         (pop),
        .lookup_data_i (miss_entry),
        .head_data_o   (head_raw),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .lookup_hit_o  (lookup_hit)
    );

    // Miss admission, FSM next state, beat assembly and registered output values.
    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        beats_d        = beats_q;
        mem_req_d      = mem_req_q;
        mem_req_addr_d = mem_req_addr_q;
        update_d       = 1'b0;
        upd_addr_d     = '0;
        line1_d        = '0;
        line2_d        = '0;
        upd_pid_d      = '0;
        upd_tid_d      = '0;
        upd_id_d       = '0;

        // The head stays queued until UPDATE, so it also covers the in-flight refill.
        pop        = (state_q == UPDATE);
        is_dup     = |lookup_hit;
        push       = cacheMiss_i && !is_dup && (!fifo_full || pop);
        overflow_d = cacheMiss_i && !is_dup && fifo_full && !pop;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d        = REQ;
                    mem_req_d      = 1'b1;
                    mem_req_addr_d = lineAddress(head_entry.address);
                end
            end
            REQ: begin
                if (memReqReady_i) begin
                    state_d        = WAIT;
                    mem_req_d      = 1'b0;
                    mem_req_addr_d = '0;
                    beat_cnt_d     = '0;
                end
            end
            WAIT: begin
                if (memRespValid_i) begin
                    if (beat_cnt_q == LastBeat) begin
                        state_d              = UPDATE;
                        update_d             = 1'b1;
                        {line1_d, line2_d}   = {beats_q, memRespData_i};
                        upd_addr_d           = head_entry.address;
                        upd_pid_d            = head_entry.pid;
                        upd_tid_d            = head_entry.tid;
                        upd_id_d             = head_entry.inst_major_id;
                    end else begin
                        beats_d    = {beats_q[(BeatsPerRefill-2)*BeatWidth-1:0], memRespData_i};
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and outputs registered; synchronous active-low reset clears everything.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q        <= IDLE;
            beat_cnt_q     <= '0;
            beats_q        <= '0;
            mem_req_q      <= 1'b0;
            mem_req_addr_q <= '0;
            overflow_q     <= 1'b0;
            update_q       <= 1'b0;
            upd_addr_q     <= '0;
            line1_q        <= '0;
            line2_q        <= '0;
            upd_pid_q      <= '0;
            upd_tid_q      <= '0;
            upd_id_q       <= '0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            beats_q        <= beats_d;
            mem_req_q      <= mem_req_d;
            mem_req_addr_q <= mem_req_addr_d;
            overflow_q     <= overflow_d;
            update_q       <= update_d;
            upd_addr_q     <= upd_addr_d;
            line1_q        <= line1_d;
            line2_q        <= line2_d;
            upd_pid_q      <= upd_pid_d;
            upd_tid_q      <= upd_tid_d;
            upd_id_q       <= upd_id_d;
        end
    end

    assign missOverflow_o           = overflow_q;
    assign memReq_o                 = mem_req_q;
    assign memReqAddress_o          = mem_req_addr_q;
    assign cacheUpdate_o            = update_q;
    assign cacheUpdateAddress_o     = upd_addr_q;
    assign cacheUpdateLine1_o       = line1_q;
    assign cacheUpdateLine2_o       = line2_q;
    assign cacheUpdatePid_o         = upd_pid_q;
    assign cacheUpdateTid_o         = upd_tid_q;
    assign cacheUpdateInstMajorId_o = upd_id_q;
    assign busy_o                   = (state_q != IDLE) || !fifo_empty;
    assign fsmState_o               = state_q;

endmodule

// File: tb/tb_l1i_refill_controller.sv
// Bench for l1i_refill_controller: directed scenarios, a queue-based reference
// model checked every cycle, and literal expectations at key points.
module tb_l1i_refill_controller;
    import l1i_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                               reset_i;
    logic                               cacheMiss_i;
    logic [FetchingAddressWidth-1:0]    missedAddress_i;
    logic [InstructionCounterWidth-1:0] missedInstMajorId_i;
    logic [PidSize-1:0]                 missedPid_i;
    logic [TidSize-1:0]                 missedTid_i;
    logic                               missOverflow_o;
    logic                               memReq_o;
    logic [FetchingAddressWidth-1:0]    memReqAddress_o;
    logic                               memReqReady_i;
    logic                               memRespValid_i;
    logic [BeatWidth-1:0]               memRespData_i;
    logic                               cacheUpdate_o;
    logic [FetchingAddressWidth-1:0]    cacheUpdateAddress_o;
    logic [CacheLineWith-1:0]           cacheUpdateLine1_o;
    logic [CacheLineWith-1:0]           cacheUpdateLine2_o;
    logic [PidSize-1:0]                 cacheUpdatePid_o;
    logic [TidSize-1:0]                 cacheUpdateTid_o;
    logic [InstructionCounterWidth-1:0] cacheUpdateInstMajorId_o;
    logic                               busy_o;
    logic [1:0]                         fsmState_o;

    l1i_refill_controller dut (
        .clock_i(clk), .reset_i(reset_i), .cacheMiss_i(cacheMiss_i),
        .missedAddress_i(missedAddress_i), .missedInstMajorId_i(missedInstMajorId_i),
        .missedPid_i(missedPid_i), .missedTid_i(missedTid_i),
        .missOverflow_o(missOverflow_o), .memReq_o(memReq_o),
        .memReqAddress_o(memReqAddress_o), .memReqReady_i(memReqReady_i),
        .memRespValid_i(memRespValid_i), .memRespData_i(memRespData_i),
        .cacheUpdate_o(cacheUpdate_o), .cacheUpdateAddress_o(cacheUpdateAddress_o),
        .cacheUpdateLine1_o(cacheUpdateLine1_o), .cacheUpdateLine2_o(cacheUpdateLine2_o),
        .cacheUpdatePid_o(cacheUpdatePid_o), .cacheUpdateTid_o(cacheUpdateTid_o),
        .cacheUpdateInstMajorId_o(cacheUpdateInstMajorId_o), .busy_o(busy_o),
        .fsmState_o(fsmState_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    miss_entry_t         mq[$];
    logic [BeatWidth-1:0] got[$];
    bit model_live = 0;
    bit m_requesting = 0, m_collecting = 0, m_strobing = 0;
    logic                               m_req, m_upd, m_ovf, m_busy, m_active;
    logic [FetchingAddressWidth-1:0]    m_req_addr, m_upd_addr;
    logic [CacheLineWith-1:0]           m_line1, m_line2;
    logic [PidSize-1:0]                 m_pid;
    logic [TidSize-1:0]                 m_tid;
    logic [InstructionCounterWidth-1:0] m_id;

    always @(posedge clk) begin
        bit popping, dup, take;
        miss_entry_t e;
        popping = 0; dup = 0; take = 0;
        if (!reset_i) begin
            mq.delete();
            got.delete();
            m_requesting = 0; m_collecting = 0; m_strobing = 0;
            m_ovf = 0;
            model_live = 1;
        end else if (model_live) begin
            popping = m_strobing;
            m_ovf   = 0;
            if (cacheMiss_i) begin
                foreach (mq[i])
                    if ((mq[i].address >> OffsetWidth) == (missedAddress_i >> OffsetWidth) &&
                        mq[i].pid == missedPid_i)
                        dup = 1;
                if (!dup) begin
                    if (mq.size() < QueueDepth || popping) take = 1;
                    else m_ovf = 1;
                end
            end
            if (popping) begin
                void'(mq.pop_front());
                m_strobing = 0;
            end else if (m_collecting) begin
                if (memRespValid_i) begin
                    got.push_back(memRespData_i);
                    if (got.size() == BeatsPerRefill) begin
                        m_collecting = 0;
                        m_strobing   = 1;
                    end
                end
            end else if (m_requesting) begin
                if (memReqReady_i) begin
                    m_requesting = 0;
                    m_collecting = 1;
                    got.delete();
                end
            end else if (mq.size() != 0) begin
                m_requesting = 1;
            end
            if (take) begin
                e.address = missedAddress_i;
                e.inst_major_id = missedInstMajorId_i;
                e.pid = missedPid_i;
                e.tid = missedTid_i;
                mq.push_back(e);
            end
        end
        m_req      = m_requesting;
        m_req_addr = m_requesting ? {mq[0].address[FetchingAddressWidth-1:OffsetWidth], 6'b0} : '0;
        m_upd      = m_strobing;
        m_upd_addr = m_strobing ? mq[0].address : '0;
        m_line1    = m_strobing ? {got[0], got[1]} : '0;
        m_line2    = m_strobing ? {got[2], got[3]} : '0;
        m_pid      = m_strobing ? mq[0].pid : '0;
        m_tid      = m_strobing ? mq[0].tid : '0;
        m_id       = m_strobing ? mq[0].inst_major_id : '0;
        m_active   = m_requesting || m_collecting || m_strobing;
        m_busy     = m_active || (mq.size() != 0);
    end

    // ---------------- compare process / monitor ----------------
    int req_starts = 0, upd_count = 0, ovf_count = 0;
    logic prev_req = 1'b0;
    logic [FetchingAddressWidth-1:0] upd_log[$];

    always @(negedge clk) begin
        if (model_live) begin
            check("missOverflow_o", 512'(missOverflow_o), 512'(m_ovf));
            check("memReq_o", 512'(memReq_o), 512'(m_req));
            check("memReqAddress_o", 512'(memReqAddress_o), 512'(m_req_addr));
            check("cacheUpdate_o", 512'(cacheUpdate_o), 512'(m_upd));
            check("cacheUpdateAddress_o", 512'(cacheUpdateAddress_o), 512'(m_upd_addr));
            check("cacheUpdateLine1_o", cacheUpdateLine1_o, m_line1);
            check("cacheUpdateLine2_o", cacheUpdateLine2_o, m_line2);
            check("cacheUpdatePid_o", 512'(cacheUpdatePid_o), 512'(m_pid));
            check("cacheUpdateTid_o", 512'(cacheUpdateTid_o), 512'(m_tid));
            check("cacheUpdateInstMajorId_o", 512'(cacheUpdateInstMajorId_o), 512'(m_id));
            check("busy_o", 512'(busy_o), 512'(m_busy));
            check("fsm_active", 512'(fsmState_o != 2'd0), 512'(m_active));
            if (memReq_o === 1'b1 && prev_req !== 1'b1) req_starts++;
            prev_req = memReq_o;
            if (cacheUpdate_o === 1'b1) begin
                upd_count++;
                upd_log.push_back(cacheUpdateAddress_o);
            end
            if (missOverflow_o === 1'b1) ovf_count++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_miss(input logic [63:0] a, input logic [19:0] p,
                              input logic [15:0] t, input logic [63:0] id);
        cacheMiss_i = 1'b1; missedAddress_i = a; missedPid_i = p;
        missedTid_i = t; missedInstMajorId_i = id;
        tick();
        cacheMiss_i = 1'b0;
    endtask

    task automatic wait_req(output int cycles);
        cycles = 0;
        while (memReq_o !== 1'b1 && cycles < 50) begin
            tick();
            cycles++;
        end
        n_checks++;
        if (memReq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_req: memReq_o=%b after %0d cycles, expected 1", memReq_o, cycles);
        end
    endtask

    task automatic accept_req(input int delay);
        repeat (delay) tick();
        memReqReady_i = 1'b1;
        tick();
        memReqReady_i = 1'b0;
    endtask

    task automatic send_beats(input logic [255:0] b0, input logic [255:0] b1,
                              input logic [255:0] b2, input logic [255:0] b3,
                              input int gap, input int count);
        logic [255:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int i = 0; i < count; i++) begin
            repeat (gap) tick();
            memRespValid_i = 1'b1;
            memRespData_i  = b[i];
            tick();
            memRespValid_i = 1'b0;
            memRespData_i  = '0;
        end
    endtask

    task automatic serve(input logic [255:0] b0, input logic [255:0] b1,
                         input logic [255:0] b2, input logic [255:0] b3);
        int k;
        wait_req(k);
        accept_req(0);
        send_beats(b0, b1, b2, b3, 0, 4);
    endtask

    // ---------------- stimulus ----------------
    logic [255:0] B0, B1, B2, B3, C0, C1, C2, C3, JUNK;
    int k, r0, u0, o0;

    initial begin
        B0 = {32{8'h10}}; B1 = {32{8'h21}}; B2 = {32{8'h32}}; B3 = {32{8'h43}};
        C0 = {16{16'hC0C0}}; C1 = {16{16'hC1C1}}; C2 = {16{16'hC2C2}}; C3 = {16{16'hC3C3}};
        JUNK = {8{32'hDEADBEEF}};
        reset_i = 1'b0; cacheMiss_i = 1'b0; missedAddress_i = '0; missedInstMajorId_i = '0;
        missedPid_i = '0; missedTid_i = '0; memReqReady_i = 1'b0; memRespValid_i = 1'b0;
        memRespData_i = '0;
        repeat (3) tick();
        reset_i = 1'b1;

        // Reset state
        check("rst_memReq", 512'(memReq_o), 512'(0));
        check("rst_line1", cacheUpdateLine1_o, 512'(0));
        check("rst_busy", 512'(busy_o), 512'(0));
        tick();

        // Test 1: best-case refill of 0x40
        drive_miss(64'h40, 20'h12345, 16'hBEEF, 64'd100);
        wait_req(k);
        check("t1_miss_to_req_cycles", 512'(k), 512'(1));
        check("t1_req_addr", 512'(memReqAddress_o), 512'(64'h40));
        accept_req(0);
        send_beats(B0, B1, B2, B3, 0, 4);
        check("t1_update", 512'(cacheUpdate_o), 512'(1));
        check("t1_upd_addr", 512'(cacheUpdateAddress_o), 512'(64'h40));
        check("t1_line1", cacheUpdateLine1_o, {B0, B1});
        check("t1_line2", cacheUpdateLine2_o, {B2, B3});
        check("t1_pid", 512'(cacheUpdatePid_o), 512'(20'h12345));
        check("t1_tid", 512'(cacheUpdateTid_o), 512'(16'hBEEF));
        tick();
        check("t1_update_one_cycle", 512'(cacheUpdate_o), 512'(0));
        repeat (2) tick();

        // Test 2: duplicate line/Pid during refill is dropped
        r0 = req_starts; u0 = upd_count; o0 = ovf_count;
        drive_miss(64'h44, 20'h7, 16'h1, 64'd200);
        wait_req(k);
        accept_req(0);
        drive_miss(64'h7C, 20'h7, 16'h2, 64'd201);
        send_beats(B3, B2, B1, B0, 0, 4);
        check("t2_upd_addr", 512'(cacheUpdateAddress_o), 512'(64'h44));
        check("t2_upd_id", 512'(cacheUpdateInstMajorId_o), 512'(64'd200));
        repeat (5) tick();
        check("t2_req_count", 512'(req_starts - r0), 512'(1));
        check("t2_upd_count", 512'(upd_count - u0), 512'(1));
        check("t2_no_overflow", 512'(ovf_count - o0), 512'(0));
        check("t2_idle_busy", 512'(busy_o), 512'(0));

        // Test 3: overflow with queue depth 2
        u0 = upd_count; o0 = ovf_count;
        drive_miss(64'h000, 20'h9, 16'h3, 64'd300);
        wait_req(k);
        drive_miss(64'h100, 20'h9, 16'h3, 64'd301);
        drive_miss(64'h200, 20'h9, 16'h3, 64'd302);
        accept_req(0);
        send_beats(C0, C1, C2, C3, 0, 4);
        tick();
        serve(B0, B1, B2, B3);
        repeat (5) tick();
        check("t3_overflow_count", 512'(ovf_count - o0), 512'(1));
        check("t3_upd_count", 512'(upd_count - u0), 512'(2));
        if (upd_log.size() >= 2) begin
            check("t3_order_first", 512'(upd_log[upd_log.size()-2]), 512'(64'h000));
            check("t3_order_second", 512'(upd_log[upd_log.size()-1]), 512'(64'h100));
        end

        // Test 4: ready held low 5 cycles, beats spaced 3 cycles
        drive_miss(64'h1008, 20'h5, 16'h4, 64'd400);
        wait_req(k);
        for (int i = 0; i < 5; i++) begin
            check("t4_req_held", 512'(memReq_o), 512'(1));
            check("t4_addr_held", 512'(memReqAddress_o), 512'(64'h1000));
            tick();
        end
        memReqReady_i = 1'b1;
        tick();
        memReqReady_i = 1'b0;
        send_beats(B0, C1, B2, C3, 3, 4);
        check("t4_update_after_last", 512'(cacheUpdate_o), 512'(1));
        check("t4_line2", cacheUpdateLine2_o, {B2, C3});
        repeat (3) tick();

        // Test 5: reset mid-refill, stray beats afterwards
        u0 = upd_count;
        drive_miss(64'h2000, 20'h6, 16'h5, 64'd500);
        wait_req(k);
        accept_req(0);
        send_beats(B0, B1, B2, B3, 0, 2);
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        check("t5_rst_req", 512'(memReq_o), 512'(0));
        check("t5_rst_busy", 512'(busy_o), 512'(0));
        send_beats(B2, B3, B2, B3, 0, 2);
        repeat (3) tick();
        check("t5_no_update", 512'(upd_count - u0), 512'(0));
        check("t5_busy", 512'(busy_o), 512'(0));

        // Test 6: stray beats in IDLE ignored
        send_beats(JUNK, JUNK, JUNK, JUNK, 1, 2);
        drive_miss(64'h3040, 20'h3, 16'h6, 64'd600);
        serve(C0, C1, C2, C3);
        check("t6_line1", cacheUpdateLine1_o, {C0, C1});
        check("t6_line2", cacheUpdateLine2_o, {C2, C3});
        repeat (2) tick();

        // Test 7: full queue accepts a miss in the pop cycle
        u0 = upd_count; o0 = ovf_count;
        drive_miss(64'h5000, 20'h4, 16'h7, 64'd700);
        wait_req(k);
        drive_miss(64'h6000, 20'h4, 16'h7, 64'd701);
        accept_req(0);
        send_beats(B0, B1, B2, B3, 0, 4);
        drive_miss(64'h7000, 20'h4, 16'h7, 64'd702);
        serve(C0, C1, C2, C3);
        tick();
        serve(B3, B2, B1, B0);
        repeat (4) tick();
        check("t7_no_overflow", 512'(ovf_count - o0), 512'(0));
        check("t7_upd_count", 512'(upd_count - u0), 512'(3));
        if (upd_log.size() >= 1)
            check("t7_last_addr", 512'(upd_log[upd_log.size()-1]), 512'(64'h7000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/l1i_refill_controller.md
# l1i_refill_controller

Sequences L1 instruction-cache miss refills: captures miss reports from the L1I cache, queues them, issues one line-pair read request at a time to the next memory level, assembles the returned beats into two 512-bit cachelines and drives the cache's single-cycle update port. It sits between the L1I miss outputs and update inputs and the L2/memory request/response channel.

## Interface
- fetchingAddressWidth, 64, address width
- cacheLineWith, 512, cacheline width in bits
- offsetWidth, 6, byte-offset bits within one line
- beatWidth, 256, memory response beat width; beatsPerRefill = 2*cacheLineWith/beatWidth (4)
- PidSize, 20; TidSize, 16; instructionCounterWidth, 64, process, thread and instruction IDs
- queueDepth, 2, pending-miss FIFO entries (power of 2)

Ports:
- clock_i  in  1  clock; all state changes on the rising edge
- reset_i  in  1  synchronous, active-low reset
- cacheMiss_i  in  1  miss report valid, one cycle per miss
- missedAddress_i  in  fetchingAddressWidth  missed fetch address
- missedInstMajorId_i  in  instructionCounterWidth  ID of the missing instruction
- missedPid_i / missedTid_i  in  PidSize / TidSize  owner of the miss
- missOverflow_o  out  1  one-cycle pulse: miss dropped, queue full
- memReq_o  out  1  read request valid
- memReqAddress_o  out  fetchingAddressWidth  line-aligned request address
- memReqReady_i  in  1  memory accepts request
- memRespValid_i  in  1  response beat valid
- memRespData_i  in  beatWidth  response beat
- cacheUpdate_o  out  1  one-cycle update strobe to the cache
- cacheUpdateAddress_o  out  fetchingAddressWidth  original missed address
- cacheUpdateLine1_o / cacheUpdateLine2_o  out  cacheLineWith  missing line / next sequential line
- cacheUpdatePid_o / cacheUpdateTid_o  out  PidSize / TidSize  owner
- cacheUpdateInstMajorId_o  out  instructionCounterWidth  ID of the refilled miss
- busy_o  out  1  FSM not IDLE or queue non-empty

## Operation
- Enqueue on cacheMiss_i: {address, instMajorId, Pid, Tid}.
- Duplicate suppression: a miss whose line address (address with low offsetWidth bits cleared) and Pid match a queued or in-flight entry is silently dropped. It is not an overflow.
- Full queue with a non-duplicate miss: drop it and pulse missOverflow_o. If a pop happens in the same cycle, the queue is not full and the miss is accepted.
- FSM states:
  - IDLE: queue non-empty → REQ.
  - REQ: memReq_o=1 with the head line address; memReqAddress_o is stable while waiting; memReqReady_i=1 at an edge → WAIT with beat counter 0.
  - WAIT: each memRespValid_i edge stores memRespData_i into beat slot[counter] and increments the counter; storing the last beat → UPDATE.
  - UPDATE: cacheUpdate_o=1 for exactly one cycle, head popped → IDLE.
- Beat packing: beat 0 fills the most significant bits of Line1, i.e. bits [0:beatWidth-1]. Beats fill Line1, then Line2, in big-endian bit order.
- memRespValid_i outside WAIT is ignored.
- Only one request is outstanding at a time.
- Reset (reset_i=0 at an edge): queue emptied, FSM → IDLE, counter 0, all outputs 0. This applies mid-refill too; later stray beats are ignored because the FSM is in IDLE.

## Timing
- Reset values: every output 0, including data buses.
- Best case, miss sampled at edge E:
  - memReq_o high in cycle E+1.
  - With ready=1, beats arrive on edges E+3..E+6.
  - cacheUpdate_o high in cycle E+6 → E+7.
- Back-to-back queued misses: next memReq_o one cycle after the UPDATE cycle, via IDLE.
- cacheUpdate_o is never high for two consecutive cycles.
- Update outputs are registered and hold their values only during the strobe cycle; they read 0 otherwise.

## Structure
- Shared package l1i_pkg:
  - FSM state enum (IDLE, REQ, WAIT, UPDATE)
  - miss-entry struct {address, instMajorId, Pid, Tid}
  - lineAddress function (clears the offset bits)
- Sub-module miss_fifo: parameterised synchronous FIFO with push/pop/full/empty and per-entry lookup ports for duplicate compare.
- FSM, beat counter and line assembly stay in the top level.

## Test plan
- Reset, then miss at 0x40, ready=1, beats B0..B3 on consecutive cycles → memReqAddress_o=0x40; cacheUpdate_o one cycle with Line1={B0,B1}, Line2={B2,B3}, address 0x40, Pid/Tid echoed.
- Miss at 0x44, then 0x7C with the same Pid, both during the same refill → exactly one memReq_o and one cacheUpdate_o.
- Misses at 0x000, 0x100 and 0x200 while the first refill is in flight (queueDepth 2) → third miss pulses missOverflow_o; two updates occur, in order 0x000 then 0x100.
- memReqReady_i held 0 for 5 cycles, and response beats spaced 3 cycles apart → memReq_o and its address stable throughout; update occurs one cycle after the 4th beat.
- reset_i low after 2 of 4 beats, then 2 stray beats → all outputs 0, no cacheUpdate_o, busy_o=0.
- Stray memRespValid_i in IDLE, then a new miss → the refill assembles only beats received in WAIT.
